om_sd_tx: RTL
=============

# om_sd_tx

Parallel-to-online digit transmitter for the radix-2 online multiplier. Loads two N-bit two's-complement operands and streams them MSD-first as radix-2 signed digits on the x/y digit pair the multiplier stages consume. After the N operand digits it appends ONLINE_DELAY zero digits so the multiplier residual can finish. Sits between the parallel operand source and the first online-multiplier stage; it is the producing end of the x/y digit interface.

## Interface
- N, default 8: operand width in bits, equal to the number of operand digits; N >= 2.
- ONLINE_DELAY, default 2: number of trailing zero digits appended after the operand digits; >= 0.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  load request, sampled only in IDLE.
- a_in  input  N  operand X, two's complement; value a_int * 2^-N.
- b_in  input  N  operand Y, same format.
- dig_ready  input  1  consumer accepts the current digit this cycle.
- x  output  2  X digit.
- y  output  2  Y digit.
- dig_valid  output  1  x/y hold a digit.
- dig_first  output  1  current digit is digit 1 (weight 2^-1).
- dig_last  output  1  current digit is the final one, operand or pad.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last digit is accepted.

## Operation
- Digit encoding is {p,n}: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0. The code 2'b11 is never driven.
- Recoding, for digit j with weight 2^-j:
  - d1 = -a[N-1]: sign bit 1 gives 2'b01, sign bit 0 gives 2'b00.
  - dj = a[N-j] for j = 2..N: bit 1 gives 2'b10, bit 0 gives 2'b00.
  - The sum of dj * 2^-j equals a_int * 2^-N exactly. The same rule applies to Y.
- States:
  - IDLE: start high captures a_in/b_in into shift registers, clears the digit counter, and moves to DIGITS.
  - DIGITS: dig_valid = 1. Each accepted digit advances the counter and shifts both registers left. After digit N is accepted, go to PAD; if ONLINE_DELAY = 0, go to DONE.
  - PAD: x = y = 2'b00 and dig_valid = 1. After ONLINE_DELAY accepted digits, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- A digit is accepted when dig_valid & dig_ready. With dig_ready low, x, y, dig_first and dig_last hold and the counter does not advance.
- dig_first is high only while digit 1 is presented. dig_last is high only on the digit with index N + ONLINE_DELAY.
- start while busy is ignored and does not queue. Operand inputs are sampled only on the accepted start.
- Counter width is clog2(N + ONLINE_DELAY + 1). It counts accepted digits from 0 and never wraps within an operation.

## Timing
- All outputs are registered. Reset values: x = y = 2'b00; dig_valid, dig_first, dig_last, busy, done = 0; state = IDLE.
- With start sampled high at edge 0 and dig_ready held high:
  - digit j is presented in cycle j, for j = 1..N+ONLINE_DELAY;
  - done is high in cycle N + ONLINE_DELAY + 1;
  - start is accepted again from cycle N + ONLINE_DELAY + 2.
- Total occupancy is N + ONLINE_DELAY + 2 cycles per operation.
- rst asserted mid-stream forces the reset values immediately (asynchronously) and abandons the operation; no done pulse is produced.
- dig_ready low in the same cycle as dig_last extends the hold. done follows the edge on which the final digit is accepted.

## Structure
- Shared package om_pkg holds:
  - the digit constants SD_POS = 2'b10, SD_NEG = 2'b01, SD_ZERO = 2'b00;
  - the state enum (IDLE, DIGITS, PAD, DONE).
- The multiplier stages use the same constants from om_pkg.
- Sub-module om_sd_recode is combinational: inputs are the current MSB and an is_first flag, output is the 2-bit digit. It is instanced once for X and once for Y.

## Test plan
- N=4, D=2, a_in=4'b1010 (-0.375), b_in=4'b0111 (0.4375), dig_ready=1:
  - x = 01,00,10,00,00,00;
  - y = 00,10,10,10,00,00;
  - dig_first in cycle 1, dig_last in cycle 6, done in cycle 7.
- a_in=4'b1000, b_in=4'b0000: x = 01,00,00,00 then 2 pad zeros; y all 00; 2'b11 never appears.
- dig_ready low for 3 cycles during digit 2: x/y/dig_first/dig_last hold; done is delayed exactly 3 cycles.
- start pulsed during DIGITS with different operands: ignored; the stream matches the first operands and busy stays high.
- rst asserted during PAD: all outputs 0 with no clock edge needed; a following start runs a clean full sequence.
- Randomized operands, N=8, D=3, compared against a reference model:
  - sum of dj * 2^-j equals a_int * 2^-8;
  - the digit count is exactly 11.

Source files
------------

// File: rtl/om_pkg.sv
// Shared definitions for the radix-2 online multiplier datapath:
// signed-digit codes and the transmitter state encoding.
package om_pkg;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        PAD,
        DONE
    } state_t;

endpackage

// File: rtl/om_sd_recode.sv
// Maps one two's-complement bit to a radix-2 signed digit; the sign bit
// (first digit) carries negative weight, every other bit positive weight.
module om_sd_recode
    import om_pkg::*;
(
    input  logic       msb,
    input  logic       is_first,
    output logic [1:0] dig
);

    always_comb begin
        dig = SD_ZERO;
        if (msb) begin
            dig = is_first ? SD_NEG : SD_POS;
        end
    end

endmodule

// File: rtl/om_sd_tx.sv
// Streams two loaded operands MSD-first as signed digits, then ONLINE_DELAY
// zero pad digits; outputs are registered and hold while dig_ready is low.
module om_sd_tx
    import om_pkg::*;
#(
    parameter int N            = 8,
    parameter int ONLINE_DELAY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         dig_ready,
    output logic [1:0]   x,
    output logic [1:0]   y,
    output logic         dig_valid,
    output logic         dig_first,
    output logic         dig_last,
    output logic         busy,
    output logic         done
);

    localparam int TOTAL = N + ONLINE_DELAY;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] CNT_N = CW'(N);
    localparam logic [CW-1:0] CNT_T = CW'(TOTAL);

    state_t        state, state_nx;
    logic [N-1:0]  sa, sb, sa_nx, sb_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc, cnt_inc2;
    logic [1:0]    x_nx, y_nx, rx, ry;
    logic          vld_nx, first_nx, last_nx, busy_nx, done_nx;
    logic          accept, rec_first, rec_msb_a, rec_msb_b;

    // In IDLE the first digit comes straight from the operand inputs so it
    // can be registered on the same edge that accepts start.
    assign rec_first = (state == IDLE);
    assign rec_msb_a = rec_first ? a_in[N-1] : sa[N-1];
    assign rec_msb_b = rec_first ? b_in[N-1] : sb[N-1];

    om_sd_recode u_rec_x (.msb(rec_msb_a), .is_first(rec_first), .dig(rx));
    om_sd_recode u_rec_y (.msb(rec_msb_b), .is_first(rec_first), .dig(ry));

    assign accept   = dig_valid & dig_ready;
    assign cnt_inc  = cnt + CW'(1);
    assign cnt_inc2 = cnt + CW'(2);

    always_comb begin
        state_nx = state;
        sa_nx    = sa;
        sb_nx    = sb;
        cnt_nx   = cnt;
        x_nx     = x;
        y_nx     = y;
        vld_nx   = dig_valid;
        first_nx = dig_first;
        last_nx  = dig_last;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = DIGITS;
                    sa_nx    = {a_in[N-2:0], 1'b0};
                    sb_nx    = {b_in[N-2:0], 1'b0};
                    cnt_nx   = '0;
                    x_nx     = rx;
                    y_nx     = ry;
                    vld_nx   = 1'b1;
                    first_nx = 1'b1;
                    last_nx  = 1'b0;
                end
            end
            DIGITS: begin
                if (accept) begin
                    cnt_nx   = cnt_inc;
                    first_nx = 1'b0;
                    if (cnt_inc == CNT_N) begin
                        x_nx = SD_ZERO;
                        y_nx = SD_ZERO;
                        if (ONLINE_DELAY == 0) begin
                            state_nx = DONE;
                            vld_nx   = 1'b0;
                            last_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = PAD;
                            last_nx  = (cnt_inc2 == CNT_T);
                        end
                    end else begin
                        x_nx    = rx;
                        y_nx    = ry;
                        sa_nx   = {sa[N-2:0], 1'b0};
                        sb_nx   = {sb[N-2:0], 1'b0};
                        last_nx = (cnt_inc2 == CNT_T);
                    end
                end
            end
            PAD: begin
                if (accept) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == CNT_T) begin
                        state_nx = DONE;
                        vld_nx   = 1'b0;
                        last_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        last_nx = (cnt_inc2 == CNT_T);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                vld_nx   = 1'b0;
                first_nx = 1'b0;
                last_nx  = 1'b0;
                x_nx     = SD_ZERO;
                y_nx     = SD_ZERO;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            cnt       <= '0;
            x         <= SD_ZERO;
            y         <= SD_ZERO;
            dig_valid <= 1'b0;
            dig_first <= 1'b0;
            dig_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            sa        <= sa_nx;
            sb        <= sb_nx;
            cnt       <= cnt_nx;
            x         <= x_nx;
            y         <= y_nx;
            dig_valid <= vld_nx;
            dig_first <= first_nx;
            dig_last  <= last_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule
